// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX     = 4'd5;
  localparam logic [3:0] ONES_MAX         = 4'd9;
  localparam int         TICK_DIV_DEFAULT = 100000000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button pulses in, BCD display and status out; slave side is the controller.
interface stopwatch_ctrl_if;

  logic       start_stop_pulse;
  logic       clear_pulse;
  logic       lap_pulse;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       wrap_pulse;
  logic       lap_active;

  modport master (
    output start_stop_pulse, clear_pulse, lap_pulse,
    input  min_tens, min_ones, sec_tens, sec_ones, running, wrap_pulse, lap_active
  );

  modport slave (
    input  start_stop_pulse, clear_pulse, lap_pulse,
    output min_tens, min_ones, sec_tens, sec_ones, running, wrap_pulse, lap_active
  );

endinterface

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD digit of the stopwatch count; carry is combinational so digits chain in one cycle.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc_en,
  input  logic       clr,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc_en) begin
      value_d = (value_q == MAX) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc_en && (value_q == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch FSM, 1 Hz prescaler and MM:SS BCD count.
// Optional display freeze (lap) enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT,
  parameter int PRESC_W  = 27
) (
  input  logic               clk,
  input  logic               rst,
  stopwatch_ctrl_if.slave    sw
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_e             state_q, state_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               running_q, running_d;
  logic               wrap_q, wrap_d;
  logic               tick;
  logic [3:0]         c_sec_ones, c_sec_tens, c_min_ones, c_min_tens;
  logic               cy_sec_ones, cy_sec_tens, cy_min_ones, cy_min_tens;

  // Clear takes priority over a coincident tick, so no carry reaches the digits.
  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST) && !sw.clear_pulse;

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    case (state_q)
      ST_IDLE: begin
        if (sw.start_stop_pulse) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end
      ST_RUN: begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
        if (sw.start_stop_pulse) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (sw.start_stop_pulse) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
        presc_d = '0;
      end
    endcase
    if (sw.clear_pulse) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end
    running_d = (state_d == ST_RUN);
    wrap_d    = cy_min_tens;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
    end
  end

  bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk(clk), .rst(rst), .inc_en(tick), .clr(sw.clear_pulse),
    .value(c_sec_ones), .carry(cy_sec_ones)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk(clk), .rst(rst), .inc_en(cy_sec_ones), .clr(sw.clear_pulse),
    .value(c_sec_tens), .carry(cy_sec_tens)
  );

  bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk(clk), .rst(rst), .inc_en(cy_sec_tens), .clr(sw.clear_pulse),
    .value(c_min_ones), .carry(cy_min_ones)
  );

  bcd_digit #(.MAX(SEC_TENS_MAX)) u_min_tens (
    .clk(clk), .rst(rst), .inc_en(cy_min_ones), .clr(sw.clear_pulse),
    .value(c_min_tens), .carry(cy_min_tens)
  );

  assign sw.running    = running_q;
  assign sw.wrap_pulse = wrap_q;

`ifdef STOPWATCH_LAP_EN
  logic        lap_q, lap_d;
  logic [15:0] snap_q, snap_d;
  logic [15:0] live;

  assign live = {c_min_tens, c_min_ones, c_sec_tens, c_sec_ones};

  always_comb begin
    lap_d  = lap_q;
    snap_d = snap_q;
    if (sw.clear_pulse) begin
      lap_d = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (sw.start_stop_pulse) begin
        lap_d = 1'b0;
      end else if (sw.lap_pulse) begin
        lap_d = !lap_q;
        if (!lap_q) snap_d = live;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q  <= 1'b0;
      snap_q <= '0;
    end else begin
      lap_q  <= lap_d;
      snap_q <= snap_d;
    end
  end

  assign {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones} = lap_q ? snap_q : live;
  assign sw.lap_active = lap_q;
`else
  logic unused_lap_pulse;
  assign unused_lap_pulse = sw.lap_pulse;

  assign sw.min_tens   = c_min_tens;
  assign sw.min_ones   = c_min_ones;
  assign sw.sec_tens   = c_sec_tens;
  assign sw.sec_ones   = c_sec_ones;
  assign sw.lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a 4-cycle tick; define STOPWATCH_LAP_EN to exercise lap.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   vec  = 0;
  int   errs = 0;

  stopwatch_ctrl_if sw_if ();

  stopwatch_ctrl #(.TICK_DIV(4), .PRESC_W(2)) dut (
    .clk(clk),
    .rst(rst),
    .sw (sw_if)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] disp();
    return {sw_if.min_tens, sw_if.min_ones, sw_if.sec_tens, sw_if.sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vec++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic ss, input logic cl, input logic lp);
    sw_if.start_stop_pulse = ss;
    sw_if.clear_pulse      = cl;
    sw_if.lap_pulse        = lp;
    step(1);
    sw_if.start_stop_pulse = 1'b0;
    sw_if.clear_pulse      = 1'b0;
    sw_if.lap_pulse        = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sw_if.start_stop_pulse = 1'b0;
    sw_if.clear_pulse      = 1'b0;
    sw_if.lap_pulse        = 1'b0;
    #1;
    chk("rst_disp", disp(), 16'h0000);
    chk("rst_running", {15'd0, sw_if.running}, 16'd0);
    chk("rst_wrap", {15'd0, sw_if.wrap_pulse}, 16'd0);
    chk("rst_lap", {15'd0, sw_if.lap_active}, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1);

    // start from IDLE, first two seconds
    pulse(1'b1, 1'b0, 1'b0);
    chk("start_running", {15'd0, sw_if.running}, 16'd1);
    chk("start_disp", disp(), 16'h0000);
    step(3);
    chk("pre_tick1", disp(), 16'h0000);
    step(1);
    chk("tick1", disp(), 16'h0001);
    step(4);
    chk("tick2", disp(), 16'h0002);

    // pause two cycles into a second, hold, resume
    step(1);
    pulse(1'b1, 1'b0, 1'b0);
    chk("pause_running", {15'd0, sw_if.running}, 16'd0);
    chk("pause_disp", disp(), 16'h0002);
    step(20);
    chk("paused_hold", disp(), 16'h0002);
    chk("paused_running", {15'd0, sw_if.running}, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    chk("resume_running", {15'd0, sw_if.running}, 16'd1);
    chk("resume_disp", disp(), 16'h0002);
    step(1);
    chk("resume_plus1", disp(), 16'h0002);
    step(1);
    chk("resume_plus2", disp(), 16'h0003);

    // asynchronous reset between edges while running at 00:03
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_disp", disp(), 16'h0000);
    chk("async_rst_running", {15'd0, sw_if.running}, 16'd0);
    #1;
    rst = 1'b0;
    step(2);
    chk("post_rst_idle", disp(), 16'h0000);
    chk("post_rst_running", {15'd0, sw_if.running}, 16'd0);

    // long run through every carry to the full wrap
    pulse(1'b1, 1'b0, 1'b0);
    step(40);
    chk("carry_00_10", disp(), 16'h0010);
    step(240);
    chk("carry_01_10", disp(), 16'h0110);
    step(14116);
    chk("at_59_59", disp(), 16'h5959);
    chk("at_59_59_wrap", {15'd0, sw_if.wrap_pulse}, 16'd0);
    step(3);
    chk("hold_59_59", disp(), 16'h5959);
    step(1);
    chk("wrap_disp", disp(), 16'h0000);
    chk("wrap_pulse_hi", {15'd0, sw_if.wrap_pulse}, 16'd1);
    chk("wrap_running", {15'd0, sw_if.running}, 16'd1);
    step(1);
    chk("wrap_pulse_lo", {15'd0, sw_if.wrap_pulse}, 16'd0);
    chk("wrap_running2", {15'd0, sw_if.running}, 16'd1);
    step(3);
    chk("after_wrap_tick", disp(), 16'h0001);

    // clear, run to 01:07, then start_stop and clear together
    pulse(1'b0, 1'b1, 1'b0);
    chk("clear_disp", disp(), 16'h0000);
    chk("clear_running", {15'd0, sw_if.running}, 16'd0);
    pulse(1'b1, 1'b0, 1'b0);
    step(268);
    chk("at_01_07", disp(), 16'h0107);
    pulse(1'b1, 1'b1, 1'b0);
    chk("both_disp", disp(), 16'h0000);
    chk("both_running", {15'd0, sw_if.running}, 16'd0);
    chk("both_wrap", {15'd0, sw_if.wrap_pulse}, 16'd0);
    step(8);
    chk("both_stays_idle", disp(), 16'h0000);
    chk("both_idle_running", {15'd0, sw_if.running}, 16'd0);

    // tick coinciding with start_stop: tick applied, then paused
    pulse(1'b1, 1'b0, 1'b0);
    step(3);
    chk("pre_tick_pause", disp(), 16'h0000);
    pulse(1'b1, 1'b0, 1'b0);
    chk("tick_pause_disp", disp(), 16'h0001);
    chk("tick_pause_running", {15'd0, sw_if.running}, 16'd0);
    step(10);
    chk("tick_pause_hold", disp(), 16'h0001);

    // tick coinciding with clear: clear wins, no wrap
    pulse(1'b1, 1'b0, 1'b0);
    step(3);
    chk("pre_tick_clear", disp(), 16'h0001);
    pulse(1'b0, 1'b1, 1'b0);
    chk("tick_clear_disp", disp(), 16'h0000);
    chk("tick_clear_running", {15'd0, sw_if.running}, 16'd0);
    chk("tick_clear_wrap", {15'd0, sw_if.wrap_pulse}, 16'd0);

`ifdef STOPWATCH_LAP_EN
    pulse(1'b1, 1'b0, 1'b0);
    step(20);
    chk("lap_pre", disp(), 16'h0005);
    pulse(1'b0, 1'b0, 1'b1);
    chk("lap_on", {15'd0, sw_if.lap_active}, 16'd1);
    chk("lap_on_disp", disp(), 16'h0005);
    step(8);
    chk("lap_frozen", disp(), 16'h0005);
    chk("lap_frozen_active", {15'd0, sw_if.lap_active}, 16'd1);
    pulse(1'b0, 1'b0, 1'b1);
    chk("lap_off", {15'd0, sw_if.lap_active}, 16'd0);
    chk("lap_off_live", disp(), 16'h0007);
    pulse(1'b0, 1'b0, 1'b1);
    chk("lap_again", {15'd0, sw_if.lap_active}, 16'd1);
    chk("lap_again_disp", disp(), 16'h0007);
    pulse(1'b0, 1'b1, 1'b0);
    chk("lap_clear_active", {15'd0, sw_if.lap_active}, 16'd0);
    chk("lap_clear_disp", disp(), 16'h0000);
`else
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    chk("nolap_active", {15'd0, sw_if.lap_active}, 16'd0);
    step(7);
    chk("nolap_live", disp(), 16'h0002);
    chk("nolap_active2", {15'd0, sw_if.lap_active}, 16'd0);
    pulse(1'b0, 1'b1, 1'b0);
    chk("nolap_clear", disp(), 16'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Downstream consumer of the debounced button pulses. Takes one-cycle start/stop and clear pulses and runs a stopped/running/paused state machine. Drives a BCD MM:SS count from an internal 1 Hz prescaler. Outputs feed the seven-segment display mux.

Parameters:
TICK_DIV, 100000000, clk cycles per one-second count tick (>=2)
PRESC_W, 27, prescaler width; must hold TICK_DIV-1

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
start_stop_pulse  input  1  one-cycle debounced pulse; toggles run/pause
clear_pulse  input  1  one-cycle debounced pulse; zeroes count and stops
lap_pulse  input  1  one-cycle pulse; used only with LAP_EN, ignored otherwise
min_tens  output  4  BCD 0-5
min_ones  output  4  BCD 0-9
sec_tens  output  4  BCD 0-5
sec_ones  output  4  BCD 0-9
running  output  1  high while in RUN
wrap_pulse  output  1  one-cycle pulse when the count rolls 59:59 -> 00:00
lap_active  output  1  high while the display is frozen (LAP_EN only, else tied 0)

Behaviour:
- Reset (async, rst=1): state=IDLE, all digits 0, prescaler 0, running=0, wrap_pulse=0, lap_active=0. Outputs take their reset values immediately, without waiting for a clock edge.
- All outputs are registered. An input pulse sampled at edge n takes effect in the outputs after edge n.
- States:
  - IDLE: count is 00:00, stopped.
  - RUN: counting.
  - PAUSE: count held.
- Transitions:
  - IDLE + start_stop -> RUN, prescaler cleared to 0.
  - RUN + start_stop -> PAUSE, prescaler value held (not cleared).
  - PAUSE + start_stop -> RUN, prescaler resumes from its held value.
  - Any state + clear -> IDLE: digits 0, prescaler 0.
- Simultaneous start_stop and clear: clear wins. Final state is IDLE and start_stop is discarded.
- Prescaler:
  - In RUN only, increments each cycle over 0..TICK_DIV-1.
  - When it equals TICK_DIV-1 it wraps to 0 and the count advances by one second on that same edge.
- Count advance (BCD ripple):
  - sec_ones 9 -> 0 carries into sec_tens.
  - sec_tens 5 -> 0 carries into min_ones.
  - min_ones 9 -> 0 carries into min_tens.
  - min_tens 5 -> 0 is a full wrap.
- Full wrap 59:59 -> 00:00: stay in RUN and assert wrap_pulse for exactly one cycle, coincident with the digits showing 00:00.
- A tick coinciding with start_stop in RUN: the tick is applied, then the state moves to PAUSE.
- A tick coinciding with clear: clear wins, count is 00:00, no wrap_pulse.
- A start_stop pulse held high for more than one cycle is treated as one toggle per high cycle. Upstream guarantees single-cycle pulses, and this block adds no edge detection.
- running = (state==RUN), registered.

Optional Feature:
Macro: STOPWATCH_LAP_EN
- Defined:
  - lap_pulse in RUN toggles lap_active.
  - While lap_active=1, the four digit outputs show a snapshot latched at the lap_pulse edge, while the internal count keeps running.
  - A second lap_pulse releases the freeze; outputs show the live count on the next cycle.
  - clear or entering PAUSE forces lap_active=0.
  - lap_pulse in IDLE or PAUSE is ignored.
- Undefined:
  - lap_pulse is ignored, lap_active is tied 0, and the digit outputs are always live.
  - No snapshot registers are synthesised.

Decomposition:
- Shared package stopwatch_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2.
  - BCD limit constants SEC_TENS_MAX=5, ONES_MAX=9.
  - Default TICK_DIV.
- One sub-module, bcd_digit: a 4-bit counter with parameter MAX, inputs inc_en and clr, outputs value and carry.
  - carry is combinational and equals inc_en && value==MAX.
  - It is instantiated four times in a carry chain.
- FSM and prescaler stay in the top module.

Test Plan:
Simulate all scenarios with TICK_DIV=4.
1. Reset mid-RUN at count 00:03: assert rst asynchronously between edges -> digits 00:00, running=0 before the next posedge.
2. start_stop at cycle 0 from IDLE -> running=1 after edge 0; sec_ones=1 after 4 cycles and 2 after 8 cycles.
3. Run, pause 2 cycles into a tick, wait 20 cycles, resume -> sec_ones unchanged while paused; it advances 2 cycles after resume, since the prescaler value was held.
4. Preload via 3599 ticks to 59:59 (or run long) -> next tick gives 00:00, wrap_pulse high for exactly 1 cycle, running stays 1.
5. start_stop and clear asserted in the same cycle during RUN at 01:07 -> state IDLE, 00:00, running=0, wrap_pulse=0.
6. STOPWATCH_LAP_EN defined: lap_pulse at 00:05, run 8 more cycles -> outputs hold 00:05 with lap_active=1. A second lap_pulse -> outputs show 00:07 the next cycle. A clear while frozen -> lap_active=0, 00:00.
